// File: rtl/vga_dither_quantizer.sv
// Output stage for the TinyVGA PMOD: 4x4 ordered-dither quantisation of 8-bit RGB to 2 bits
// per channel, with per-frame threshold rotation and sync/blank delay-matched over 2 clocks.
module vga_dither_quantizer #(
  parameter int TEMPORAL = 1,
  parameter int FRAME_W  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [23:0]        rgb_in,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic               display_on,
  input  logic [1:0]         hpos_lo,
  input  logic [1:0]         vpos_lo,
  input  logic [1:0]         mode,
  output logic [7:0]         uo_out,
  output logic [FRAME_W-1:0] frame_cnt
);

  // 4x4 Bayer matrix, indexed by pixel row then column.
  function automatic logic [3:0] bayer_threshold(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] t;
    case ({row, col})
      4'h0: t = 4'd0;   4'h1: t = 4'd8;   4'h2: t = 4'd2;   4'h3: t = 4'd10;
      4'h4: t = 4'd12;  4'h5: t = 4'd4;   4'h6: t = 4'd14;  4'h7: t = 4'd6;
      4'h8: t = 4'd3;   4'h9: t = 4'd11;  4'hA: t = 4'd1;   4'hB: t = 4'd9;
      4'hC: t = 4'd15;  4'hD: t = 4'd7;   4'hE: t = 4'd13;  4'hF: t = 4'd5;
      default: t = 4'd0;
    endcase
    return t;
  endfunction

  // Add dither offset and keep the top two bits, saturating at 3 on overflow.
  function automatic logic [1:0] quantize(input logic [7:0] c, input logic [5:0] d);
    logic [8:0] s;
    logic [1:0] q;
    s = {1'b0, c} + {3'b000, d};
    if (s[8]) q = 2'd3;
    else      q = s[7:6];
    return q;
  endfunction

  logic               vsync_d_r;
  logic [FRAME_W-1:0] frame_cnt_r;
  logic [1:0]         mode_q_r;
  logic               vsync_rise_s;
  logic [1:0]         frame_lo_s;
  logic [3:0]         t_base_s;
  logic [3:0]         t_s;
  logic [5:0]         dither_s;
  logic [9:0]         luma_sum_s;
  logic [7:0]         c_red_s, c_grn_s, c_blu_s;
  logic [1:0]         q_red_r, q_grn_r, q_blu_r;
  logic               hs1_r, vs1_r, de1_r;
  logic [1:0]         r_out_s, g_out_s, b_out_s;

  assign vsync_rise_s = vsync_in & ~vsync_d_r;
  assign frame_cnt    = frame_cnt_r;

  if (FRAME_W >= 2) begin : g_frame_wide
    assign frame_lo_s = frame_cnt_r[1:0];
  end else begin : g_frame_narrow
    assign frame_lo_s = {1'b0, frame_cnt_r[0]};
  end

  // Frame counter and mode latch update only on a vsync rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsync_d_r   <= 1'b0;
      frame_cnt_r <= '0;
      mode_q_r    <= 2'd0;
    end else begin
      vsync_d_r <= vsync_in;
      if (vsync_rise_s) begin
        frame_cnt_r <= frame_cnt_r + FRAME_W'(1);
        mode_q_r    <= mode;
      end
    end
  end

  // Threshold selection, optional luma mixing and per-channel quantisation inputs.
  always_comb begin
    t_base_s   = bayer_threshold(vpos_lo, hpos_lo);
    t_s        = t_base_s;
    dither_s   = 6'd0;
    luma_sum_s = {2'b00, rgb_in[23:16]} + {1'b0, rgb_in[15:8], 1'b0} + {2'b00, rgb_in[7:0]};
    c_red_s    = rgb_in[23:16];
    c_grn_s    = rgb_in[15:8];
    c_blu_s    = rgb_in[7:0];
    // Four-bit add wraps the rotated threshold modulo 16.
    if ((TEMPORAL != 0) && (mode_q_r == 2'd2)) t_s = t_base_s + {frame_lo_s, 2'b00};
    else                                       t_s = t_base_s;
    case (mode_q_r)
      2'd0:    dither_s = 6'd0;
      default: dither_s = {t_s, 2'b00};
    endcase
    if (mode_q_r == 2'd3) begin
      c_red_s = luma_sum_s[9:2];
      c_grn_s = luma_sum_s[9:2];
      c_blu_s = luma_sum_s[9:2];
    end else begin
      c_red_s = rgb_in[23:16];
      c_grn_s = rgb_in[15:8];
      c_blu_s = rgb_in[7:0];
    end
  end

  // Stage 1: quantised colour plus delayed sync and blank.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_red_r <= 2'd0;
      q_grn_r <= 2'd0;
      q_blu_r <= 2'd0;
      hs1_r   <= 1'b0;
      vs1_r   <= 1'b0;
      de1_r   <= 1'b0;
    end else begin
      q_red_r <= quantize(c_red_s, dither_s);
      q_grn_r <= quantize(c_grn_s, dither_s);
      q_blu_r <= quantize(c_blu_s, dither_s);
      hs1_r   <= hsync_in;
      vs1_r   <= vsync_in;
      de1_r   <= display_on;
    end
  end

  // Blank the colour bits outside the visible area; sync passes through.
  always_comb begin
    r_out_s = 2'd0;
    g_out_s = 2'd0;
    b_out_s = 2'd0;
    if (de1_r) begin
      r_out_s = q_red_r;
      g_out_s = q_grn_r;
      b_out_s = q_blu_r;
    end else begin
      r_out_s = 2'd0;
      g_out_s = 2'd0;
      b_out_s = 2'd0;
    end
  end

  // Stage 2: pack into the PMOD pin order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      uo_out <= 8'h00;
    end else begin
      uo_out <= {hs1_r, b_out_s[0], g_out_s[0], r_out_s[0],
                 vs1_r, b_out_s[1], g_out_s[1], r_out_s[1]};
    end
  end

endmodule
